// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - table-driven memory initialiser with optional readback verify
//
// Purpose:
//   On a start pulse, walks a compile-time table of {addr, data} entries in
//   index order and issues one write per entry to a simple req/ack memory
//   port. When MEM_LOADER_VERIFY_EN is defined, it then reads every entry
//   back. It flags the first index whose read data differs from the table.
//
// Build option:
//   MEM_LOADER_VERIFY_EN - adds the READ state and the compare/err logic.
//                          Without it, mem_re/err/err_idx are tied to 0 and
//                          mem_rd is ignored.
//
// Parameters:
//   DEPTH    - number of init table entries (>= 1)
//   ADDR_W   - memory address width
//   DATA_W   - memory data width
//   INIT_TBL - [DEPTH-1:0] entries of {addr[ADDR_W-1:0], data[DATA_W-1:0]}
//
// Ports:
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   start    in   one-cycle request to begin a sequence (IDLE/DONE only)
//   busy     out  sequence in progress (WRITE or READ)
//   done     out  sequence complete, held until next accepted start
//   err      out  sticky readback-mismatch flag
//   err_idx  out  index of first mismatching entry
//   mem_addr out  request address
//   mem_wd   out  write data
//   mem_we   out  write request
//   mem_re   out  read request
//   mem_rd   in   read data, valid with mem_ack during a read
//   mem_ack  in   completes the pending request when sampled high

module mem_loader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter logic [DEPTH-1:0][ADDR_W+DATA_W-1:0] INIT_TBL = '0,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  err_idx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              mem_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef MEM_LOADER_VERIFY_EN
    localparam logic [1:0] S_READ  = 2'd3;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ADDR_W+DATA_W-1:0] entry;
    logic [ADDR_W-1:0]        entry_addr;
    logic [DATA_W-1:0]        entry_data;
    logic                     start_accept;
    logic                     last_entry;

    assign entry      = INIT_TBL[idx_q];
    assign entry_addr = entry[ADDR_W+DATA_W-1:DATA_W];
    assign entry_data = entry[DATA_W-1:0];
    assign last_entry = (idx_q == LAST_IDX);

    // start only has an effect from a resting state; mid-sequence it is dropped
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // ------------------------------------------------------------------
    // Sequencer: idx only advances on an ack that completes a live request,
    // so stray acks in IDLE/DONE never move it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accept) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    if (last_entry) begin
                        idx_d = '0;
`ifdef MEM_LOADER_VERIFY_EN
                        state_d = S_READ;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            S_READ: begin
                if (mem_ack) begin
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Readback compare
    // ------------------------------------------------------------------
`ifdef MEM_LOADER_VERIFY_EN
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;

    // err is sticky for the whole pass; err_idx latches only the first miss
    always_comb begin
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (start_accept) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end else if ((state_q == S_READ) && mem_ack && (mem_rd != entry_data)) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_idx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign err     = err_q;
    assign err_idx = err_idx_q;
    assign mem_re  = (state_q == S_READ);
`else
    logic unused_rd;

    assign unused_rd = ^mem_rd;
    assign err       = 1'b0;
    assign err_idx   = '0;
    assign mem_re    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Memory port: decoded straight from state/idx so that an asynchronous
    // reset clears the request lines immediately. The bus is zeroed while
    // no request is pending.
    // ------------------------------------------------------------------
    assign mem_we   = (state_q == S_WRITE);
    assign mem_addr = (mem_we || mem_re) ? entry_addr : '0;
    assign mem_wd   = mem_we ? entry_data : '0;

    assign busy = mem_we || mem_re;
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader

module tb_mem_loader;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int ACK_DLY = 3;

    localparam int M_IDLE  = 0;
    localparam int M_WRITE = 1;
    localparam int M_READ  = 2;
    localparam int M_DONE  = 3;

`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    function automatic logic [47:0] tbl_entry(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[15:0], kk * 32'h1111_1111};
    endfunction

    function automatic logic [DEPTH-1:0][47:0] make_tbl();
        logic [DEPTH-1:0][47:0] t;
        for (int k = 0; k < DEPTH; k++) t[k] = tbl_entry(k);
        return t;
    endfunction

    localparam logic [DEPTH-1:0][47:0] TBL = make_tbl();

    logic              clk;
    logic              resetn;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_idx;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_ack;

    mem_loader #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INIT_TBL(TBL)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_idx (err_idx),
        .mem_addr(mem_addr),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
        .mem_re  (mem_re),
        .mem_rd  (mem_rd),
        .mem_ack (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_writes;
    int wcnt;
    bit ack_tied;

    // model of the sequence
    int m_phase;
    int m_k;
    bit m_err;
    int m_err_idx;

    // what the DUT saw at the previous rising edge
    logic              p_start, p_ack, p_we;
    logic [DATA_W-1:0] p_rd, p_wd;
    logic [ADDR_W-1:0] p_addr;

    logic [31:0] mem_m [0:255];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE;
        m_k = 0;
        m_err = 1'b0;
        m_err_idx = 0;
        p_start = 1'b0; p_ack = 1'b0; p_we = 1'b0;
        p_rd = '0; p_wd = '0; p_addr = '0;
        wcnt = 0;
    endtask

    // Called once per cycle at the falling edge: advance model, compare, drive.
    task automatic step(input logic st);
        logic [47:0] e;
        bit          exp_req;
        if (p_start && (m_phase == M_IDLE || m_phase == M_DONE)) begin
            m_phase = M_WRITE; m_k = 0; m_err = 1'b0; m_err_idx = 0;
        end else if (p_ack && m_phase == M_WRITE) begin
            m_k++;
            if (m_k == DEPTH) begin
                m_k = 0;
                m_phase = VERIFY ? M_READ : M_DONE;
            end
        end else if (p_ack && m_phase == M_READ) begin
            e = tbl_entry(m_k);
            if (p_rd !== e[31:0]) begin
                if (!m_err) m_err_idx = m_k;
                m_err = 1'b1;
            end
            m_k++;
            if (m_k == DEPTH) begin
                m_k = 0;
                m_phase = M_DONE;
            end
        end
        if (p_ack && p_we) begin
            mem_m[p_addr[7:0]] = p_wd;
            n_writes++;
        end

        e = tbl_entry(m_k);
        exp_req = (m_phase == M_WRITE) || (m_phase == M_READ);
        chk("busy", 64'(busy), 64'(exp_req));
        chk("done", 64'(done), 64'(m_phase == M_DONE));
        chk("mem_we", 64'(mem_we), 64'(m_phase == M_WRITE));
        chk("mem_re", 64'(mem_re), 64'(m_phase == M_READ));
        chk("we_re_excl", 64'(mem_we & mem_re), 64'(0));
        if (exp_req) chk("mem_addr", 64'(mem_addr), 64'(e[47:32]));
        if (m_phase == M_WRITE) chk("mem_wd", 64'(mem_wd), 64'(e[31:0]));
        chk("err", 64'(err), 64'(m_err));
        chk("err_idx", 64'(err_idx), 64'(m_err_idx));

        start = st;
        if (ack_tied) begin
            mem_ack = 1'b1;
        end else if (mem_we || mem_re) begin
            if (wcnt == ACK_DLY) begin
                mem_ack = 1'b1; wcnt = 0;
            end else begin
                mem_ack = 1'b0; wcnt++;
            end
        end else begin
            mem_ack = 1'b0; wcnt = 0;
        end
        // memory returns corrupted data on addresses 2 and 5
        mem_rd = mem_m[mem_addr[7:0]] ^
                 (((mem_addr == 16'd2) || (mem_addr == 16'd5)) ? 32'hFFFF_0000 : 32'h0);
        p_start = st; p_ack = mem_ack; p_we = mem_we;
        p_rd = mem_rd; p_addr = mem_addr; p_wd = mem_wd;
        cyc++;
    endtask

    // Start at offset 0 (optionally again at extra_start) and run to done.
    task automatic run_seq(input int budget, input int extra_start,
                           output int first_we, output int done_at,
                           output int we_cycles, output logic [15:0] first_addr);
        first_we = -1; done_at = -1; we_cycles = 0; n_writes = 0; first_addr = '1;
        @(negedge clk);
        step(1'b1);
        for (int b = 1; b < budget && done_at < 0; b++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cycles++;
                if (first_we < 0) begin
                    first_we = b;
                    first_addr = mem_addr;
                end
            end
            if (done) done_at = b;
            step(b == extra_start);
        end
        if (done_at < 0) begin
            n_tests++; n_fail++;
            $display("FAIL seq_timeout cyc=%0d actual=no_done required=done", cyc);
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_err_idx"}, 64'(err_idx), 64'(0));
        chk({tag, "_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_re"}, 64'(mem_re), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_wd"}, 64'(mem_wd), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int          fw, da, wc;
        logic [15:0] fa;
        resetn = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rd = '0;
        ack_tied = 1'b1; n_writes = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        model_reset();
        #1;
        rst_checks("rst");
        @(negedge clk); step(1'b0);
        @(negedge clk); resetn = 1'b1; step(1'b0);
        @(negedge clk); step(1'b0);

        // A: ack tied high, start at cycle 0
        ack_tied = 1'b1;
        run_seq(60, -1, fw, da, wc, fa);
        chk("A_first_we", 64'(fw), 64'(1));
        chk("A_we_cycles", 64'(wc), 64'(8));
        chk("A_writes", 64'(n_writes), 64'(8));
        chk("A_done_cycle", 64'(da), VERIFY ? 64'(17) : 64'(9));
        chk("A_mem3", 64'(mem_m[3]), 64'h3333_3333);
        chk("A_mem7", 64'(mem_m[7]), 64'h7777_7777);
        chk("A_err", 64'(err), VERIFY ? 64'(1) : 64'(0));
        chk("A_err_idx", 64'(err_idx), VERIFY ? 64'(2) : 64'(0));

        // B: every request acked after 3 wait cycles, started from DONE
        ack_tied = 1'b0;
        run_seq(300, -1, fw, da, wc, fa);
        chk("B_first_we", 64'(fw), 64'(1));
        chk("B_we_cycles", 64'(wc), 64'(32));
        chk("B_writes", 64'(n_writes), 64'(8));
        chk("B_done_cycle", 64'(da), VERIFY ? 64'(65) : 64'(33));
        chk("B_err_idx", 64'(err_idx), VERIFY ? 64'(2) : 64'(0));

        // C: second start mid-WRITE must be ignored
        ack_tied = 1'b1;
        run_seq(60, 3, fw, da, wc, fa);
        chk("C_first_we", 64'(fw), 64'(1));
        chk("C_writes", 64'(n_writes), 64'(8));
        chk("C_done_cycle", 64'(da), VERIFY ? 64'(17) : 64'(9));

        // D: reset while entry 4 is pending, then re-run from entry 0
        ack_tied = 1'b0;
        @(negedge clk); step(1'b1);
        for (int b = 0; b < 100 && !(m_phase == M_WRITE && m_k == 4); b++) begin
            @(negedge clk); step(1'b0);
        end
        chk("D_at_entry4", 64'(mem_addr), 64'h4);
        #2 resetn = 1'b0;
        #1 rst_checks("D_rst");
        @(negedge clk);
        rst_checks("D_rst_held");
        resetn = 1'b1; mem_ack = 1'b0;
        model_reset();
        ack_tied = 1'b1;
        repeat (3) begin
            @(negedge clk); step(1'b0);
        end
        run_seq(60, -1, fw, da, wc, fa);
        chk("D_first_we", 64'(fw), 64'(1));
        chk("D_first_addr", 64'(fa), 64'h0);
        chk("D_writes", 64'(n_writes), 64'(8));
        chk("D_done_cycle", 64'(da), VERIFY ? 64'(17) : 64'(9));

        @(negedge clk); step(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of init table entries (minimum 1).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the memory data width.
REQ-004 The block SHALL have parameter INIT_TBL, an array [DEPTH-1:0] of (ADDR_W+DATA_W)-bit entries; each entry is {addr[ADDR_W-1:0], data[DATA_W-1:0]}, with addr in the upper bits; default is all zeros.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a load sequence.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high after a sequence completes.
REQ-010 The block SHALL have port err, output, 1 bit: sticky readback-mismatch flag.
REQ-011 The block SHALL have port err_idx, output, $clog2(DEPTH) bits (minimum 1): index of the first mismatching entry.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: request address.
REQ-013 The block SHALL have port mem_wd, output, DATA_W bits: write data.
REQ-014 The block SHALL have port mem_we, output, 1 bit: write request.
REQ-015 The block SHALL have port mem_re, output, 1 bit: read request.
REQ-016 The block SHALL have port mem_rd, input, DATA_W bits: read data, valid in the cycle mem_ack is high during a read.
REQ-017 The block SHALL have port mem_ack, input, 1 bit: completes the pending request in the cycle it is sampled high.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL: clear index, done, err and err_idx; then move to WRITE.
REQ-020 start SHALL be ignored in WRITE and READ.
REQ-021 With start sampled high at edge n, mem_we SHALL be high from cycle n+1.
REQ-022 In WRITE, the block SHALL drive mem_we=1, mem_addr=INIT_TBL[idx] upper field and mem_wd=INIT_TBL[idx] lower field, holding them stable until mem_ack=1.
REQ-023 On mem_ack in WRITE, idx SHALL increment; back-to-back acks SHALL complete one entry per cycle with no bubble.
REQ-024 Entries SHALL be processed in index order 0 to DEPTH-1.
REQ-025 On the ack of entry DEPTH-1 in WRITE, the FSM SHALL go to READ with idx=0 if MEM_LOADER_VERIFY_EN is defined, else to DONE.
REQ-026 In READ, the block SHALL drive mem_re=1 and mem_addr from entry idx, holding them until mem_ack.
REQ-027 On each READ ack, if mem_rd differs from the entry data field, err SHALL be set; if err was 0 at that point, err_idx SHALL capture idx.
REQ-028 Reading SHALL continue through all entries after a mismatch; later mismatches SHALL NOT change err_idx.
REQ-029 On the READ ack of entry DEPTH-1, the FSM SHALL go to DONE.
REQ-030 busy SHALL equal (state==WRITE || state==READ).
REQ-031 done SHALL equal (state==DONE), holding high until the next start.
REQ-032 mem_we and mem_re SHALL never be high together and SHALL both be 0 in IDLE and DONE.
REQ-033 mem_ack SHALL be ignored when no request is pending.
REQ-034 The idx counter SHALL be $clog2(DEPTH) bits and SHALL never exceed DEPTH-1.

Reset
REQ-035 resetn low SHALL immediately force: state=IDLE, idx=0, busy=0, done=0, err=0, err_idx=0, mem_we=0, mem_re=0, mem_addr=0, mem_wd=0.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence; after release the block SHALL wait in IDLE for start.

Configuration
REQ-037 Macro MEM_LOADER_VERIFY_EN defined SHALL compile in the READ state and compare logic.
REQ-038 Without MEM_LOADER_VERIFY_EN: READ state SHALL be absent, mem_re SHALL be constant 0, err and err_idx SHALL be constant 0, and mem_rd SHALL be unused.

Verification
REQ-039 DEPTH=8, entry k = {16'hk, 32'hk*0x11111111}, mem_ack tied 1, start at cycle 0 -> 8 consecutive writes on cycles 1..8, done=1 from cycle 9.
REQ-040 mem_ack delayed 3 cycles per request -> mem_addr and mem_wd stable while waiting; exactly 8 writes in order.
REQ-041 With VERIFY_EN and a model memory corrupting address 2 and 5 on readback -> err=1 and err_idx=2 at done.
REQ-042 resetn pulsed low during write of entry 4 -> outputs reset asynchronously; a new start re-runs from entry 0.
REQ-043 start pulsed during WRITE -> ignored; start in DONE -> done cleared, new sequence begins the next cycle.
REQ-044 Every cycle -> mem_we & mem_re never both 1; busy == !(IDLE||DONE).
